// File: rtl/wra_pkg.sv
// Shared widths, beat count and FSM state encoding for the WRA result write-back path.
package wra_pkg;

    localparam int RW    = 512;
    localparam int OW    = 128;
    localparam int AW    = 12;
    localparam int CW    = 16;
    localparam int BEATS = RW / OW;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CAPT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_FIN   = 3'd4
    } wb_state_e;

endpackage

// File: rtl/wra_wb_serializer.sv
// Splits one RW-bit result word into RW/OW output beats, lane 0 first, and holds
// each beat stable on the valid/ready port until the sink accepts it.
module wra_wb_serializer #(
    parameter int RW = wra_pkg::RW,
    parameter int OW = wra_pkg::OW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [RW-1:0] load_data,
    input  logic          last_word,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    output logic          word_done
);
    import wra_pkg::*;

    localparam int NBEATS = RW / OW;
    localparam int BW     = $clog2(NBEATS);

    logic [RW-1:0] shreg;
    logic [BW-1:0] beat_idx;
    logic          valid_q;
    logic          accept;
    logic          final_beat;

    assign accept     = valid_q && out_ready;
    assign final_beat = (beat_idx == BW'(NBEATS - 1));

    // Shifting right by one lane per accept keeps the current beat in the low lane,
    // so out_data needs no wide multiplexer.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge value of its neighbours, regardless of statement order.
        if (rst) begin
            // NOTE: the data register is reset only because out_data must read 0
            // after reset; bulk datapath storage normally needs no reset.
            shreg    <= '0;
            beat_idx <= '0;
            valid_q  <= 1'b0;
        end else if (load) begin
            shreg    <= load_data;
            beat_idx <= '0;
            valid_q  <= 1'b1;
        end else if (accept) begin
            shreg    <= {{OW{1'b0}}, shreg[RW-1:OW]};
            beat_idx <= beat_idx + 1'b1;
            if (final_beat) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = shreg[OW-1:0];
    assign out_valid = valid_q;
    assign out_last  = valid_q && final_beat && last_word;
    assign word_done = accept && final_beat;

    assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

endmodule

// File: rtl/wra_result_writeback.sv
// Drain controller: fetches result-buffer words from a start address and streams them
// out as OW-bit beats; busy covers the whole transfer and done pulses for one cycle at the end.
module wra_result_writeback #(
    parameter int RW = wra_pkg::RW,
    parameter int OW = wra_pkg::OW,
    parameter int AW = wra_pkg::AW,
    parameter int CW = wra_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] word_cnt,
    output logic          res_rd,
    output logic [AW-1:0] res_addr,
    input  logic [RW-1:0] res_data,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);
    import wra_pkg::*;

    wb_state_e     state;
    wb_state_e     state_next;
    logic [AW-1:0] cur_addr;
    logic [CW-1:0] words_left;
    logic          last_word;
    logic          load;
    logic          word_done;

    assign last_word = (words_left == CW'(1));

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through
        // the case statement leaves one unassigned and infers a latch.
        state_next = state;
        res_rd     = 1'b0;
        load       = 1'b0;
        busy       = (state != ST_IDLE);
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (word_cnt == '0) ? ST_FIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                res_rd     = 1'b1;
                state_next = ST_CAPT;
            end
            ST_CAPT: begin
                load       = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (word_done) begin
                    state_next = last_word ? ST_FIN : ST_FETCH;
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // cur_addr only advances when another fetch follows, so res_addr keeps showing
    // the last word read once the transfer ends; the address wraps modulo 2^AW.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            words_left <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start) begin
                cur_addr   <= base_addr;
                words_left <= word_cnt;
            end else if (word_done) begin
                words_left <= words_left - 1'b1;
                if (!last_word) begin
                    cur_addr <= cur_addr + 1'b1;
                end
            end
        end
    end

    assign res_addr = cur_addr;

    wra_wb_serializer #(
        .RW (RW),
        .OW (OW)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (res_data),
        .last_word (last_word),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .word_done (word_done)
    );

    assert property (@(posedge clk) disable iff (rst) done |=> !done);
    assert property (@(posedge clk) disable iff (rst) out_valid |-> (state == ST_SEND));

endmodule

// File: tb/tb_wra_result_writeback.sv
// Randomised scoreboard bench: transfers push expected reads/beats, a negedge monitor pops and compares.
module tb_wra_result_writeback;
    import wra_pkg::*;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] word_cnt  = '0;
    logic          res_rd;
    logic [AW-1:0] res_addr;
    logic [RW-1:0] res_data  = '0;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    wra_result_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .res_rd    (res_rd),
        .res_addr  (res_addr),
        .res_data  (res_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    logic [RW-1:0] mem [1 << AW];
    logic [RW-1:0] junk;
    logic [AW-1:0] rd_q [$];
    beat_t         beat_q [$];
    beat_t         got_beat;

    int n_vec = 0, n_err = 0;
    int cyc = 0, start_cyc = 0, last_acc_cyc = 0, done_cyc = 0;
    int n_reads = 0, n_beats = 0, n_done = 0, exp_done = 0;
    int cur_cnt = 0, ready_mode = 0;
    logic          prev_stall = 1'b0, prev_rst = 1'b1, prev_last = 1'b0;
    logic [OW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result buffer: data valid exactly one cycle after res_rd, junk otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < RW / 32; i++) junk[32*i +: 32] = $urandom;
        res_data <= res_rd ? mem[res_addr] : junk;
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
            prev_rst   = 1'b1;
        end else begin
            if (prev_stall && !prev_rst) begin
                check("hold_valid", OW'(out_valid), OW'(1));
                check("hold_data", out_data, prev_data);
                check("hold_last", OW'(out_last), OW'(prev_last));
            end
            if (start && !busy) start_cyc = cyc;
            if (res_rd) begin
                n_reads++;
                check("read_expected", OW'(rd_q.size() > 0), OW'(1));
                if (rd_q.size() > 0) check("read_addr", OW'(res_addr), OW'(rd_q.pop_front()));
            end
            if (out_valid && out_ready) begin
                n_beats++;
                check("beat_expected", OW'(beat_q.size() > 0), OW'(1));
                if (beat_q.size() > 0) begin
                    got_beat = beat_q.pop_front();
                    check("beat_data", out_data, got_beat.data);
                    check("beat_last", OW'(out_last), OW'(got_beat.last));
                    if (got_beat.last) last_acc_cyc = cyc;
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check("done_expected", OW'(exp_done > 0), OW'(1));
                if (exp_done > 0) begin
                    exp_done--;
                    check("done_time", OW'(cyc), OW'(cur_cnt == 0 ? start_cyc + 1 : last_acc_cyc + 1));
                    check("reads_left", OW'(rd_q.size()), OW'(0));
                    check("beats_left", OW'(beat_q.size()), OW'(0));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            prev_rst   = 1'b0;
        end
    end

    // Reference model: word w comes from (base + w) mod 2^AW, lanes low to high,
    // last flag only on the final lane of the final word.
    task automatic launch(input logic [AW-1:0] b, input logic [CW-1:0] n);
        logic [AW-1:0] a;
        beat_t         e;
        @(posedge clk); #1;
        base_addr = b;
        word_cnt  = n;
        start     = 1'b1;
        cur_cnt   = int'(n);
        exp_done++;
        for (int w = 0; w < int'(n); w++) begin
            a = AW'((int'(b) + w) % (1 << AW));
            rd_q.push_back(a);
            for (int j = 0; j < BEATS; j++) begin
                e.data = mem[a][OW*j +: OW];
                e.last = (w == int'(n) - 1) && (j == BEATS - 1);
                beat_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        check("done_seen", OW'(done), OW'(1));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_res_rd"}, OW'(res_rd), OW'(0));
        check({tag, "_res_addr"}, OW'(res_addr), OW'(0));
        check({tag, "_out_data"}, out_data, OW'(0));
        check({tag, "_out_valid"}, OW'(out_valid), OW'(0));
        check({tag, "_out_last"}, OW'(out_last), OW'(0));
        check({tag, "_busy"}, OW'(busy), OW'(0));
        check({tag, "_done"}, OW'(done), OW'(0));
    endtask

    initial begin
        int r0, b0, d0, k;
        logic [CW-1:0] n;

        for (int a = 0; a < (1 << AW); a++)
            for (int i = 0; i < RW / 32; i++) mem[a][32*i +: 32] = $urandom;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Two words from 0x010, sink always ready: 6 cycles per word.
        ready_mode = 0;
        r0 = n_reads; b0 = n_beats;
        launch(12'h010, 16'd2);
        wait_done(100);
        check("t1_reads", OW'(n_reads - r0), OW'(2));
        check("t1_beats", OW'(n_beats - b0), OW'(8));
        check("t1_cycles", OW'(done_cyc - start_cyc), OW'(13));

        // Zero-length transfer.
        r0 = n_reads; b0 = n_beats;
        launch(12'h123, 16'd0);
        wait_done(10);
        check("t2_reads", OW'(n_reads - r0), OW'(0));
        check("t2_beats", OW'(n_beats - b0), OW'(0));

        // Address wrap 0xFFF -> 0x000.
        r0 = n_reads;
        launch(12'hFFF, 16'd2);
        wait_done(100);
        check("t3_reads", OW'(n_reads - r0), OW'(2));

        // Alternating ready: beats must hold until accepted.
        ready_mode = 1;
        b0 = n_beats;
        launch(AW'($urandom), 16'd3);
        wait_done(300);
        check("t4_beats", OW'(n_beats - b0), OW'(12));

        // Start re-pulsed mid-transfer with other base/count.
        ready_mode = 0;
        r0 = n_reads; b0 = n_beats;
        launch(12'h100, 16'd3);
        repeat (8) @(posedge clk);
        #1;
        base_addr = 12'h555; word_cnt = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        check("t5_reads", OW'(n_reads - r0), OW'(3));
        check("t5_beats", OW'(n_beats - b0), OW'(12));

        // Start held during the FIN cycle.
        r0 = n_reads; d0 = n_done;
        launch(12'h200, 16'd1);
        wait_done(100);
        base_addr = 12'h300; word_cnt = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t5b_busy", OW'(busy), OW'(0));
        repeat (10) @(posedge clk);
        check("t5b_reads", OW'(n_reads - r0), OW'(1));
        check("t5b_dones", OW'(n_done - d0), OW'(1));

        // Reset while sending word 1 of 3.
        b0 = n_beats; d0 = n_done;
        launch(12'h040, 16'd3);
        k = 0;
        while (n_beats - b0 < 5 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("t6_reached_word1", OW'(n_beats - b0 >= 5), OW'(1));
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd_q.delete();
        beat_q.delete();
        exp_done = 0;
        @(negedge clk);
        check_quiet("t6_abort");
        repeat (20) @(posedge clk);
        check("t6_no_done", OW'(n_done - d0), OW'(0));
        b0 = n_beats;
        launch(AW'($urandom), 16'd2);
        wait_done(100);
        check("t6_restart_beats", OW'(n_beats - b0), OW'(8));

        // Randomised transfers with random backpressure.
        ready_mode = 2;
        for (int t = 0; t < 8; t++) begin
            n = CW'($urandom_range(1, 4));
            b0 = n_beats;
            launch(AW'($urandom), n);
            wait_done(400);
            check("rand_beats", OW'(n_beats - b0), OW'(4 * int'(n)));
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
